// File: rtl/elevator_call_panel_pkg.sv
// Shared definitions for the elevator call panel: floor codes, direction encoding,
// debounce default, and small floor-mask helpers.
package elevator_call_panel_pkg;

   typedef logic [1:0] floor_t;

   localparam floor_t FNONE = 2'd0;
   localparam floor_t F1    = 2'd1;
   localparam floor_t F2    = 2'd2;
   localparam floor_t F3    = 2'd3;

   typedef enum logic {
      UD_DOWN = 1'b0,
      UD_UP   = 1'b1
   } ud_e;

   localparam int unsigned DEB_CYCLES_DEFAULT = 4;
   localparam int unsigned NUM_BUTTONS        = 6;

   // One-hot mask for a floor code, bit n = floor n+1; FNONE maps to no bits.
   function automatic logic [2:0] floor_mask(input floor_t f);
      logic [2:0] m;
      case (f)
         F1:      m = 3'b001;
         F2:      m = 3'b010;
         F3:      m = 3'b100;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

   // Floors strictly above f.
   function automatic logic [2:0] above_mask(input floor_t f);
      logic [2:0] m;
      case (f)
         F1:      m = 3'b110;
         F2:      m = 3'b100;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

   // Floors strictly below f.
   function automatic logic [2:0] below_mask(input floor_t f);
      logic [2:0] m;
      case (f)
         F2:      m = 3'b001;
         F3:      m = 3'b011;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

   function automatic floor_t lowest_floor(input logic [2:0] m);
      floor_t f;
      if (m[0])      f = F1;
      else if (m[1]) f = F2;
      else if (m[2]) f = F3;
      else           f = FNONE;
      return f;
   endfunction

   function automatic floor_t highest_floor(input logic [2:0] m);
      floor_t f;
      if (m[2])      f = F3;
      else if (m[1]) f = F2;
      else if (m[0]) f = F1;
      else           f = FNONE;
      return f;
   endfunction

endpackage

// File: rtl/elevator_call_panel_if.sv
// Controller-side bundle of the call panel: service report, car position/direction,
// request lamps and next-target outputs.
interface elevator_call_panel_if;
   import elevator_call_panel_pkg::*;

   logic       svc_valid;
   floor_t     svc_floor;
   floor_t     cur_floor;
   logic       UD;
   logic [2:0] fb_lit;
   logic [2:0] call_lit;
   logic       req_any;
   logic       tgt_valid;
   floor_t     tgt_floor;
   logic       svc_ack;

   // Car controller side
   modport master (
      output svc_valid, svc_floor, cur_floor, UD,
      input  fb_lit, call_lit, req_any, tgt_valid, tgt_floor, svc_ack
   );

   // Call panel side
   modport slave (
      input  svc_valid, svc_floor, cur_floor, UD,
      output fb_lit, call_lit, req_any, tgt_valid, tgt_floor, svc_ack
   );

endinterface

// File: rtl/elevator_call_panel_button_debounce.sv
// button_debounce: 2-flop synchronizer, stable-run debouncer and registered press pulse
// for one active-low push button.
module elevator_call_panel_button_debounce #(
   parameter int unsigned DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n_i,
   output logic press_o
);

   localparam logic [3:0] CntLast = 4'(DEB_CYCLES - 1);

   logic       sync1_q, sync2_q;
   logic       deb_q, deb_d;
   logic [3:0] cnt_q, cnt_d;
   logic       press_q;

   // Two-stage synchronizer; released (1) out of reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= btn_n_i;
         sync2_q <= sync1_q;
      end
   end

   // Count consecutive samples that disagree with the debounced level; any agreeing
   // sample restarts the run.
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync2_q != deb_q) begin
         if (cnt_q == CntLast) begin
            deb_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   // Debounced level, run counter and press pulse on a 1->0 debounced transition.
   always_ff @(posedge clk) begin
      if (!reset) begin
         deb_q   <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         press_q <= deb_q & ~deb_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/elevator_call_panel.sv
// Elevator call panel: debounces six buttons, latches pending in-car and hall requests,
// clears them on service, and registers the next floor to serve.
module elevator_call_panel
   import elevator_call_panel_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   FB1,
   input  logic                   FB2,
   input  logic                   FB3,
   input  logic                   CALL1,
   input  logic                   CALL2,
   input  logic                   CALL3,
   elevator_call_panel_if.slave   bus
);

   // [2:0] in-car buttons, [5:3] hall buttons; bit order follows floor number.
   logic [NUM_BUTTONS-1:0] btn_n;
   logic [NUM_BUTTONS-1:0] press;

   assign btn_n = {CALL3, CALL2, CALL1, FB3, FB2, FB1};

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
      elevator_call_panel_button_debounce #(
         .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
         .clk     (clk),
         .reset   (reset),
         .btn_n_i (btn_n[i]),
         .press_o (press[i])
      );
   end

   logic [2:0] fb_lit_q, fb_lit_d;
   logic [2:0] call_lit_q, call_lit_d;
   logic       req_any_q, req_any_d;
   logic       svc_ack_q, svc_ack_d;
   logic       tgt_valid_q, tgt_valid_d;
   floor_t     tgt_floor_q, tgt_floor_d;
   logic [2:0] clr_mask;

   // Latch presses and apply service clears; a clear beats a same-floor press.
   always_comb begin
      svc_ack_d  = bus.svc_valid && (bus.svc_floor != FNONE);
      clr_mask   = svc_ack_d ? floor_mask(bus.svc_floor) : 3'b000;
      fb_lit_d   = (fb_lit_q | press[2:0]) & ~clr_mask;
      call_lit_d = (call_lit_q | press[5:3]) & ~clr_mask;
      req_any_d  = |(fb_lit_d | call_lit_d);
   end

   logic [2:0] pend;
   floor_t     cur;
   floor_t     up_pick, dn_pick;

   // Next target from the current pending set, preferring the travel direction.
   always_comb begin
      pend        = fb_lit_q | call_lit_q;
      cur         = (bus.cur_floor == FNONE) ? F1 : bus.cur_floor;
      up_pick     = lowest_floor(pend & above_mask(cur));
      dn_pick     = highest_floor(pend & below_mask(cur));
      tgt_floor_d = FNONE;
      if (pend == 3'b000) begin
         tgt_floor_d = FNONE;
      end else if ((pend & floor_mask(cur)) != 3'b000) begin
         tgt_floor_d = cur;
      end else if (bus.UD == UD_UP) begin
         tgt_floor_d = (up_pick != FNONE) ? up_pick : dn_pick;
      end else begin
         tgt_floor_d = (dn_pick != FNONE) ? dn_pick : up_pick;
      end
      tgt_valid_d = (tgt_floor_d != FNONE);
   end

   // Request latches, service acknowledge and registered target.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fb_lit_q    <= '0;
         call_lit_q  <= '0;
         req_any_q   <= 1'b0;
         svc_ack_q   <= 1'b0;
         tgt_valid_q <= 1'b0;
         tgt_floor_q <= FNONE;
      end else begin
         fb_lit_q    <= fb_lit_d;
         call_lit_q  <= call_lit_d;
         req_any_q   <= req_any_d;
         svc_ack_q   <= svc_ack_d;
         tgt_valid_q <= tgt_valid_d;
         tgt_floor_q <= tgt_floor_d;
      end
   end

   assign bus.fb_lit    = fb_lit_q;
   assign bus.call_lit  = call_lit_q;
   assign bus.req_any   = req_any_q;
   assign bus.svc_ack   = svc_ack_q;
   assign bus.tgt_valid = tgt_valid_q;
   assign bus.tgt_floor = tgt_floor_q;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Scoreboard bench for elevator_call_panel: a behavioural model pushes the expected
// outputs for every clock edge, a monitor pops and compares them on the falling edge.
module tb_elevator_call_panel;
   import elevator_call_panel_pkg::*;

   localparam int unsigned DEB = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] btn;   // active-low; [2:0] FB1..FB3, [5:3] CALL1..CALL3

   elevator_call_panel_if bus ();

   elevator_call_panel #(
      .DEB_CYCLES(DEB)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .FB1   (btn[0]),
      .FB2   (btn[1]),
      .FB3   (btn[2]),
      .CALL1 (btn[3]),
      .CALL2 (btn[4]),
      .CALL3 (btn[5]),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] fb;
      logic [2:0] call;
      logic       any;
      logic       ack;
      logic       tv;
      logic [1:0] tf;
   } obs_t;

   obs_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   // Next floor to serve from the rules: current floor first, then direction of travel.
   function automatic logic [2:0] ref_target(input logic [2:0] p, input logic [1:0] curf,
                                             input logic up);
      int c;
      int best;
      c    = (curf == 2'd0) ? 1 : int'(curf);
      best = 0;
      if (p == 3'b000) return 3'b000;
      if (p[c-1]) return {1'b1, 2'(c)};
      if (up) begin
         for (int f = c + 1; f <= 3; f++) if (best == 0 && p[f-1]) best = f;
         for (int f = c - 1; f >= 1; f--) if (best == 0 && p[f-1]) best = f;
      end else begin
         for (int f = c - 1; f >= 1; f--) if (best == 0 && p[f-1]) best = f;
         for (int f = c + 1; f <= 3; f++) if (best == 0 && p[f-1]) best = f;
      end
      return {1'b1, 2'(best)};
   endfunction

   // Reference model state
   logic [2:0]  m_fb = '0, m_call = '0;
   logic [5:0]  m_deb = '1, m_sched = '0;
   logic [15:0] m_hist [6];
   int          m_hlen [6];
   logic        rst_h1 = 1'b0, rst_h2 = 1'b0;
   logic [5:0]  raw_h1 = '1, raw_h2 = '1;

   always @(posedge clk) begin : model
      obs_t        e;
      logic [5:0]  synced;
      logic [5:0]  new_sched;
      logic [2:0]  clr, tg;
      logic [15:0] mask, want;
      e    = '0;
      mask = (16'd1 << DEB) - 16'd1;
      if (!reset) begin
         m_fb    = '0;
         m_call  = '0;
         m_deb   = '1;
         m_sched = '0;
         for (int b = 0; b < 6; b++) begin
            m_hist[b] = '0;
            m_hlen[b] = 0;
         end
      end else begin
         // A raw level reaches the debouncer two edges later, unless reset intervened.
         synced = (rst_h1 && rst_h2) ? raw_h2 : 6'h3f;
         tg     = ref_target(m_fb | m_call, bus.cur_floor, bus.UD);
         e.tv   = tg[2];
         e.tf   = tg[1:0];
         clr    = 3'b000;
         if (bus.svc_valid && bus.svc_floor != 2'd0) clr[bus.svc_floor - 2'd1] = 1'b1;
         m_fb   = (m_fb | m_sched[2:0]) & ~clr;
         m_call = (m_call | m_sched[5:3]) & ~clr;
         e.ack  = (clr != 3'b000);
         new_sched = '0;
         for (int b = 0; b < 6; b++) begin
            m_hist[b] = {m_hist[b][14:0], synced[b]};
            if (m_hlen[b] < 16) m_hlen[b]++;
            want = m_deb[b] ? 16'h0000 : 16'hffff;
            if (m_hlen[b] >= int'(DEB) && ((m_hist[b] & mask) == (want & mask))) begin
               if (m_deb[b]) new_sched[b] = 1'b1;
               m_deb[b] = ~m_deb[b];
            end
         end
         m_sched = new_sched;
      end
      e.fb   = m_fb;
      e.call = m_call;
      e.any  = |(m_fb | m_call);
      rst_h2 = rst_h1;
      raw_h2 = raw_h1;
      rst_h1 = reset;
      raw_h1 = btn;
      exp_q.push_back(e);
   end

   always @(negedge clk) begin : monitor
      obs_t a, e;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {bus.fb_lit, bus.call_lit, bus.req_any, bus.svc_ack, bus.tgt_valid, bus.tgt_floor};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs cycle %0d: got fb=%b call=%b any=%b ack=%b tv=%b tf=%0d, want fb=%b call=%b any=%b ack=%b tv=%b tf=%0d",
                     cyc, a.fb, a.call, a.any, a.ack, a.tv, a.tf,
                     e.fb, e.call, e.any, e.ack, e.tv, e.tf);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic serve(input logic [1:0] f);
      bus.svc_valid = 1'b1;
      bus.svc_floor = f;
      step(1);
      bus.svc_valid = 1'b0;
      bus.svc_floor = 2'd0;
   endtask

   int   hold [6];
   logic seen_fb2;

   initial begin
      reset         = 1'b0;
      btn           = '1;
      bus.svc_valid = 1'b0;
      bus.svc_floor = 2'd0;
      bus.cur_floor = 2'd1;
      bus.UD        = 1'b1;
      step(3);
      checks++;
      if (bus.fb_lit !== 3'b000 || bus.call_lit !== 3'b000 || bus.req_any !== 1'b0 ||
          bus.svc_ack !== 1'b0 || bus.tgt_valid !== 1'b0 || bus.tgt_floor !== 2'd0) begin
         errors++;
         $display("FAIL reset state: fb=%b call=%b any=%b ack=%b tv=%b tf=%0d",
                  bus.fb_lit, bus.call_lit, bus.req_any, bus.svc_ack, bus.tgt_valid,
                  bus.tgt_floor);
      end
      reset = 1'b1;
      step(3);

      // FB2 held low 20 cycles, then serve floor 2
      btn[1]   = 1'b0;
      seen_fb2 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (bus.fb_lit[1] === 1'b1) seen_fb2 = 1'b1;
      end
      checks++;
      if (!seen_fb2) begin
         errors++;
         $display("FAIL timeout: fb_lit[1] never rose within 20 cycles of FB2 held low");
      end
      btn[1] = 1'b1;
      step(4);
      serve(2'd2);
      step(3);

      // CALL3 glitch shorter than the debounce window
      btn[5] = 1'b0;
      step(3);
      btn[5] = 1'b1;
      step(12);

      // FB1 and FB3 pending from floor 2, going up then down
      bus.cur_floor = 2'd2;
      btn[0] = 1'b0;
      btn[2] = 1'b0;
      step(10);
      btn[0] = 1'b1;
      btn[2] = 1'b1;
      step(3);
      bus.UD = 1'b0;
      step(3);
      serve(2'd0);       // illegal floor: ignored
      step(2);
      serve(2'd1);
      serve(2'd3);
      step(3);

      // Hall call at floor 3, then served
      btn[5] = 1'b0;
      step(10);
      btn[5] = 1'b1;
      step(2);
      serve(2'd3);
      step(3);

      // FB1 press event coincides with service of floor 1; FB3 latches normally
      btn[0] = 1'b0;
      btn[2] = 1'b0;
      step(6);
      serve(2'd1);
      step(6);
      btn[0] = 1'b1;
      btn[2] = 1'b1;
      step(3);
      serve(2'd3);
      step(2);

      // Reset mid-debounce with FB1 held through it
      btn[0] = 1'b0;
      step(3);
      reset = 1'b0;
      step(2);
      reset = 1'b1;
      step(12);
      btn[0] = 1'b1;
      step(3);
      serve(2'd1);
      step(2);

      // Randomized buttons, service, position and direction
      for (int b = 0; b < 6; b++) hold[b] = 0;
      for (int i = 0; i < 2000; i++) begin
         for (int b = 0; b < 6; b++) begin
            if (hold[b] == 0) begin
               btn[b]  = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
               hold[b] = $urandom_range(1, 12);
            end else begin
               hold[b]--;
            end
         end
         bus.svc_valid = ($urandom_range(0, 7) == 0);
         bus.svc_floor = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) bus.cur_floor = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) bus.UD = 1'($urandom_range(0, 1));
         reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         step(1);
      end
      reset         = 1'b1;
      bus.svc_valid = 1'b0;
      btn           = '1;
      step(4);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
